// File: rtl/sw_pkg.sv
// Shared types and defaults for the stopwatch controller.
// Holds the FSM state enum, default depth/width/timeout and the mode encoding
// presented on the mode output.
package sw_pkg;

  localparam int DEF_DEPTH     = 8;
  localparam int DEF_W         = 24;
  localparam int DEF_REVIEW_TO = 250_000_000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_REVIEW = 2'd3
  } state_t;

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_RUN    = 2'd1;
  localparam logic [1:0] MODE_PAUSE  = 2'd2;
  localparam logic [1:0] MODE_REVIEW = 2'd3;

  function automatic logic [1:0] state_to_mode(input state_t s);
    logic [1:0] m;
    m = MODE_IDLE;
    case (s)
      ST_IDLE:   m = MODE_IDLE;
      ST_RUN:    m = MODE_RUN;
      ST_PAUSE:  m = MODE_PAUSE;
      ST_REVIEW: m = MODE_REVIEW;
      default:   m = MODE_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lap_buf.sv
// Lap record storage: DEPTH x W register file, one write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; writes are accepted whenever wr_en is high.
// Ports: clk; wr_en/wr_addr/wr_dat write port; rd_addr -> rd_dat read port.
// Contents are deliberately not reset; the controller's lap count gates what is readable.
module lap_buf
  import sw_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int W     = DEF_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_dat
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/sw_ctrl.sv
// Stopwatch control FSM (IDLE/RUN/PAUSE/REVIEW) with lap recording and review timeout.
// Latency: all outputs registered; dout follows din / selected lap one cycle after the edge.
// Backpressure: none; key pulses are one-cycle events, losers of a simultaneous press are dropped.
// Ports: clk, rst_n (sync, active-low); key_bs/key_rec/key_dis debounced pulses; din live time;
//        cnt_en/cnt_clr to the counter; dout to the display; lap_idx, lap_cnt, full, mode status.
// Sits between the key debouncers and the counter/display datapath in the top level.
module sw_ctrl
  import sw_pkg::*;
#(
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int W         = DEF_W,
  parameter  int REVIEW_TO = DEF_REVIEW_TO,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_bs,
  input  logic          key_rec,
  input  logic          key_dis,
  input  logic [W-1:0]  din,
  output logic          cnt_en,
  output logic          cnt_clr,
  output logic [W-1:0]  dout,
  output logic [AW-1:0] lap_idx,
  output logic [AW:0]   lap_cnt,
  output logic          full,
  output logic [1:0]    mode
);

  localparam int CW = AW + 1;
  localparam int TW = $clog2(REVIEW_TO + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(REVIEW_TO - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(REVIEW_TO);

  state_t        state_q,   state_d;
  logic [CW-1:0] lap_cnt_q, lap_cnt_d;
  logic [AW-1:0] lap_idx_q, lap_idx_d;
  logic [W-1:0]  dout_q,    dout_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic [TW-1:0] to_q,      to_d;

  logic          bs_win;
  logic          rec_win;
  logic          dis_win;
  logic          any_key;
  logic          full_now;
  logic          wr_en;
  logic [AW-1:0] idx_inc;
  logic [W-1:0]  rd_dat;

  lap_buf #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_lap_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (lap_cnt_q[AW-1:0]),
    .wr_dat  (din),
    .rd_addr (lap_idx_d),
    .rd_dat  (rd_dat)
  );

  always_comb begin
    // Only the highest-priority pulse of a simultaneous press is acted on.
    bs_win   = key_bs;
    rec_win  = key_rec & ~key_bs;
    dis_win  = key_dis & ~key_bs & ~key_rec;
    any_key  = key_bs | key_rec | key_dis;
    full_now = (lap_cnt_q == CNT_FULL);

    // Review index steps through 0..lap_cnt-1 and wraps.
    if ((CW'(lap_idx_q) + CW'(1)) >= lap_cnt_q) begin
      idx_inc = '0;
    end else begin
      idx_inc = lap_idx_q + AW'(1);
    end

    state_d   = state_q;
    lap_cnt_d = lap_cnt_q;
    lap_idx_d = lap_idx_q;
    cnt_clr_d = 1'b0;
    to_d      = '0;
    wr_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bs_win) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bs_win) begin
          state_d = ST_PAUSE;
        end else if (rec_win && !full_now) begin
          wr_en     = 1'b1;
          lap_cnt_d = lap_cnt_q + CW'(1);
        end
      end
      ST_PAUSE: begin
        if (bs_win) begin
          state_d = ST_RUN;
        end else if (rec_win) begin
          cnt_clr_d = 1'b1;
          lap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (dis_win && (lap_cnt_q != '0)) begin
          state_d   = ST_REVIEW;
          lap_idx_d = '0;
        end
      end
      ST_REVIEW: begin
        // Any pulse, even an ignored key_rec, restarts the idle timer; it saturates.
        if (any_key) begin
          to_d = '0;
        end else if (to_q != TO_MAX) begin
          to_d = to_q + TW'(1);
        end else begin
          to_d = to_q;
        end

        if (bs_win) begin
          state_d = ST_PAUSE;
        end else if (dis_win) begin
          lap_idx_d = idx_inc;
        end else if (!any_key && (to_q == TO_LAST)) begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Index and timer only carry meaning while reviewing.
    if (state_d != ST_REVIEW) begin
      lap_idx_d = '0;
      to_d      = '0;
    end

    // Display selects on the post-edge state so dout agrees with mode/lap_idx.
    dout_d = (state_d == ST_REVIEW) ? rd_dat : din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lap_cnt_q <= '0;
      lap_idx_q <= '0;
      dout_q    <= '0;
      cnt_clr_q <= 1'b0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      lap_cnt_q <= lap_cnt_d;
      lap_idx_q <= lap_idx_d;
      dout_q    <= dout_d;
      cnt_clr_q <= cnt_clr_d;
      to_q      <= to_d;
    end
  end

  assign cnt_en  = (state_q == ST_RUN);
  assign cnt_clr = cnt_clr_q;
  assign dout    = dout_q;
  assign lap_idx = lap_idx_q;
  assign lap_cnt = lap_cnt_q;
  assign full    = (lap_cnt_q == CNT_FULL);
  assign mode    = state_to_mode(state_q);

endmodule

// File: tb/tb_sw_ctrl.sv
// Bench for the stopwatch controller: directed key sequences, a behavioural
// model updated on every rising edge, and a per-cycle comparison on the falling edge.
module tb_sw_ctrl;

  localparam int DEPTH = 8;
  localparam int W     = 24;
  localparam int RTO   = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_bs = 1'b0;
  logic          key_rec = 1'b0;
  logic          key_dis = 1'b0;
  logic [W-1:0]  din = '0;
  logic          cnt_en;
  logic          cnt_clr;
  logic [W-1:0]  dout;
  logic [AW-1:0] lap_idx;
  logic [AW:0]   lap_cnt;
  logic          full;
  logic [1:0]    mode;

  always #5 clk = ~clk;

  sw_ctrl #(
    .DEPTH     (DEPTH),
    .W         (W),
    .REVIEW_TO (RTO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_bs  (key_bs),
    .key_rec (key_rec),
    .key_dis (key_dis),
    .din     (din),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .dout    (dout),
    .lap_idx (lap_idx),
    .lap_cnt (lap_cnt),
    .full    (full),
    .mode    (mode)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: 0 idle, 1 run, 2 pause, 3 review
  int           m_mode = 0;
  int           m_cnt  = 0;
  int           m_idx  = 0;
  int           m_idle = 0;
  bit           m_clr  = 1'b0;
  logic [W-1:0] m_dout = '0;
  logic [W-1:0] laps [DEPTH];

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    int k;
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_idx = 0; m_idle = 0; m_clr = 1'b0; m_dout = '0;
    end else begin
      m_clr = 1'b0;
      k = key_bs ? 1 : key_rec ? 2 : key_dis ? 3 : 0;
      case (m_mode)
        0: if (k == 1) m_mode = 1;
        1: begin
          if (k == 1) m_mode = 2;
          else if (k == 2 && m_cnt < DEPTH) begin
            laps[m_cnt] = din;
            m_cnt++;
          end
        end
        2: begin
          if (k == 1) m_mode = 1;
          else if (k == 2) begin m_clr = 1'b1; m_cnt = 0; m_mode = 0; end
          else if (k == 3 && m_cnt > 0) begin m_mode = 3; m_idx = 0; m_idle = 0; end
        end
        default: begin
          if (k != 0) m_idle = 0; else m_idle++;
          if (k == 1) m_mode = 2;
          else if (k == 3) m_idx = (m_idx + 1) % m_cnt;
          else if (k == 0 && m_idle == RTO) m_mode = 2;
        end
      endcase
      m_dout = (m_mode == 3) ? laps[m_idx] : din;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("mode",    32'(mode),    32'(m_mode));
      cmp("cnt_en",  32'(cnt_en),  32'(m_mode == 1));
      cmp("cnt_clr", 32'(cnt_clr), 32'(m_clr));
      cmp("lap_cnt", 32'(lap_cnt), 32'(m_cnt));
      cmp("full",    32'(full),    32'(m_cnt == DEPTH));
      cmp("dout",    32'(dout),    32'(m_dout));
      if (m_mode == 3) cmp("lap_idx", 32'(lap_idx), 32'(m_idx));
    end
  end

  task automatic step(input bit bs, input bit rec, input bit dis, input logic [W-1:0] d);
    key_bs = bs; key_rec = rec; key_dis = dis; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    step(0, 0, 0, 24'h0);
    step(0, 0, 0, 24'h0);
    chk_en = 1'b1;
    cmp("lit_rst_mode", 32'(mode), 32'd0);
    cmp("lit_rst_dout", 32'(dout), 32'd0);
    cmp("lit_rst_cnt",  32'(lap_cnt), 32'd0);
    cmp("lit_rst_en",   32'(cnt_en), 32'd0);
    rst_n = 1'b1;

    step(0, 1, 1, 24'h0);                 // IDLE ignores rec/dis
    cmp("lit_idle_ign", 32'(mode), 32'd0);
    step(1, 0, 0, 24'h5);                 // -> RUN
    cmp("lit_run_en", 32'(cnt_en), 32'd1);
    cmp("lit_run_dout", 32'(dout), 32'h5);
    step(1, 0, 0, 24'h0);                 // -> PAUSE
    cmp("lit_pause_en", 32'(cnt_en), 32'd0);
    step(1, 0, 0, 24'h0);                 // -> RUN
    step(0, 1, 0, 24'h000123);
    step(0, 1, 0, 24'h000456);
    cmp("lit_cnt2", 32'(lap_cnt), 32'd2);
    step(1, 1, 0, 24'h000789);            // bs wins: PAUSE, no lap
    cmp("lit_prio_mode", 32'(mode), 32'd2);
    cmp("lit_prio_cnt", 32'(lap_cnt), 32'd2);
    step(0, 0, 1, 24'h999);
    cmp("lit_rev0", 32'(dout), 32'h000123);
    step(0, 0, 1, 24'h999);
    cmp("lit_rev1", 32'(dout), 32'h000456);
    step(0, 0, 1, 24'h999);
    cmp("lit_wrap", 32'(dout), 32'h000123);
    step(0, 1, 1, 24'h999);               // rec wins and is ignored
    cmp("lit_rev_recdis", 32'(lap_idx), 32'd0);

    for (int i = 0; i < RTO - 1; i++) step(0, 0, 0, 24'(i));
    cmp("lit_to_hold", 32'(mode), 32'd3);
    step(0, 0, 0, 24'hABCDEF);
    cmp("lit_to_exit", 32'(mode), 32'd2);
    cmp("lit_to_dout", 32'(dout), 32'hABCDEF);

    step(1, 0, 0, 24'h0);
    step(0, 1, 0, 24'h000777);
    cmp("lit_cnt3", 32'(lap_cnt), 32'd3);
    step(1, 0, 0, 24'h0);
    step(0, 1, 0, 24'h0);                 // clear from PAUSE
    cmp("lit_clr_pulse", 32'(cnt_clr), 32'd1);
    cmp("lit_clr_cnt", 32'(lap_cnt), 32'd0);
    cmp("lit_clr_mode", 32'(mode), 32'd0);
    step(0, 0, 1, 24'h0);
    cmp("lit_clr_done", 32'(cnt_clr), 32'd0);
    cmp("lit_clr_dis", 32'(mode), 32'd0);

    step(1, 0, 0, 24'h0);
    for (int i = 1; i <= 9; i++) step(0, 1, 0, 24'h100000 + 24'(i));
    cmp("lit_full_cnt", 32'(lap_cnt), 32'd8);
    cmp("lit_full", 32'(full), 32'd1);
    step(1, 0, 0, 24'h0);
    step(0, 0, 1, 24'h0);
    cmp("lit_full_rev0", 32'(dout), 32'h100001);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 24'h0);
    cmp("lit_full_idx7", 32'(lap_idx), 32'd7);
    cmp("lit_full_e7", 32'(dout), 32'h100008);
    step(0, 0, 1, 24'h0);
    cmp("lit_full_wrap", 32'(dout), 32'h100001);

    rst_n = 1'b0;
    step(0, 0, 1, 24'h0);                 // reset beats key_dis in REVIEW
    cmp("lit_rrev_mode", 32'(mode), 32'd0);
    cmp("lit_rrev_cnt", 32'(lap_cnt), 32'd0);
    rst_n = 1'b1;
    step(1, 0, 0, 24'h0);
    rst_n = 1'b0;
    step(0, 1, 0, 24'h55);                // reset beats a lap write
    cmp("lit_rwr_cnt", 32'(lap_cnt), 32'd0);
    rst_n = 1'b1;
    step(0, 0, 0, 24'h0);
    step(0, 0, 0, 24'h0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
